// File: rtl/odo_nonce_dispatch.sv
// Odocrypt nonce dispatcher: issues one job per nonce to the hash cores,
// compares returned hashes against the share target and queues winners.
module odo_nonce_dispatch #(
  parameter int MAX_INFLIGHT = 16,
  parameter int WIN_DEPTH    = 4
) (
  input  logic           i_clk_h,
  input  logic           i_rst_h,
  input  logic [607:0]   i_header,
  input  logic [255:0]   i_target,
  input  logic [31:0]    i_nonce_start,
  input  logic [31:0]    i_nonce_end,
  input  logic           i_start,
  input  logic           i_sha_host_break,
  output logic           o_job_valid,
  input  logic           i_job_ready,
  output logic [639:0]   o_job_data,
  input  logic           i_res_valid,
  input  logic [255:0]   i_res_hash,
  input  logic [31:0]    i_res_nonce,
  output logic           o_ticket2moon,
  output logic           o_hash_cmplt,
  output logic           o_win_valid,
  output logic [31:0]    o_win_nonce,
  input  logic           i_win_rd,
  output logic           o_win_overflow,
  output logic           o_busy
);

  localparam int AW = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;
  localparam logic [7:0] LP_MAX = 8'(MAX_INFLIGHT);
  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(WIN_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [607:0] r_header;
  logic [255:0] r_target;
  logic [31:0]  r_cur;
  logic [31:0]  r_end;
  logic [7:0]   r_out;
  logic         r_aborted;
  logic         r_cmp_v;
  logic         r_tick;
  logic [31:0]  r_tick_nonce;
  logic         r_overflow;

  logic [31:0]  r_mem [WIN_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]  r_count;

  logic w_job_valid;
  logic w_cmplt;
  logic w_hs;
  logic w_res_cnt;
  logic w_win;
  logic w_start;
  logic w_full;
  logic w_wr;
  logic w_pop;

  assign w_hs      = w_job_valid && i_job_ready;
  assign w_res_cnt = i_res_valid && (r_out != 8'd0);
  assign w_win     = w_res_cnt && (i_res_hash <= r_target);
  assign w_start   = (r_state == S_IDLE) && i_start;
  assign w_full    = (r_count == LP_DEPTH);
  assign w_wr      = r_tick && !w_full;
  assign w_pop     = i_win_rd && (r_count != '0);

  // Next-state and handshake/pulse outputs
  always_comb begin
    w_state_nxt = r_state;
    w_job_valid = 1'b0;
    w_cmplt     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_nonce_start > i_nonce_end)
            w_state_nxt = S_DRAIN;
          else
            w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_job_valid = (r_out < LP_MAX);
        if (i_sha_host_break)
          w_state_nxt = S_DRAIN;
        else if (w_hs && (r_cur == r_end))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_out == 8'd0) && !r_cmp_v)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_cmplt     = !r_aborted && !i_sha_host_break;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, scan snapshot, in-flight count and registered compare
  always_ff @(posedge i_clk_h) begin
    if (i_rst_h) begin
      r_state      <= S_IDLE;
      r_header     <= '0;
      r_target     <= '0;
      r_cur        <= '0;
      r_end        <= '0;
      r_out        <= '0;
      r_aborted    <= 1'b0;
      r_cmp_v      <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_nonce <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_header  <= i_header;
        r_target  <= i_target;
        r_cur     <= i_nonce_start;
        r_end     <= i_nonce_end;
        r_aborted <= 1'b0;
      end else begin
        if (w_hs)
          r_cur <= r_cur + 32'd1;
        if ((r_state != S_IDLE) && i_sha_host_break)
          r_aborted <= 1'b1;
      end
      case ({w_hs, w_res_cnt})
        2'b10:   r_out <= r_out + 8'd1;
        2'b01:   r_out <= r_out - 8'd1;
        default: r_out <= r_out;
      endcase
      r_cmp_v      <= w_res_cnt;
      r_tick       <= w_win;
      r_tick_nonce <= i_res_nonce;
    end
  end

  // Winning-nonce FIFO pointers, count and sticky overflow
  always_ff @(posedge i_clk_h) begin
    if (i_rst_h) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_tick && w_full)
        r_overflow <= 1'b1;
      else if (w_start)
        r_overflow <= 1'b0;
    end
  end

  // FIFO storage, no reset needed: reads are gated by the count
  always_ff @(posedge i_clk_h) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= r_tick_nonce;
  end

  assign o_job_valid    = w_job_valid;
  assign o_job_data     = {r_cur, r_header};
  assign o_ticket2moon  = r_tick;
  assign o_hash_cmplt   = w_cmplt;
  assign o_win_valid    = (r_count != '0);
  assign o_win_nonce    = o_win_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign o_win_overflow = r_overflow;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_odo_nonce_dispatch.sv
// Scoreboard bench for odo_nonce_dispatch: directed scans with a
// behavioural hash core; a negedge monitor checks jobs and wins.
module tb_odo_nonce_dispatch;

  logic         clk = 1'b0;
  logic         rst;
  logic [607:0] header;
  logic [255:0] target;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic         start;
  logic         brk;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_data;
  logic         res_valid;
  logic [255:0] res_hash;
  logic [31:0]  res_nonce;
  logic         ticket2moon;
  logic         hash_cmplt;
  logic         win_valid;
  logic [31:0]  win_nonce;
  logic         win_rd;
  logic         win_overflow;
  logic         busy;

  always #5 clk = ~clk;

  odo_nonce_dispatch #(
    .MAX_INFLIGHT(4),
    .WIN_DEPTH(4)
  ) dut (
    .i_clk_h(clk),
    .i_rst_h(rst),
    .i_header(header),
    .i_target(target),
    .i_nonce_start(nonce_start),
    .i_nonce_end(nonce_end),
    .i_start(start),
    .i_sha_host_break(brk),
    .o_job_valid(job_valid),
    .i_job_ready(job_ready),
    .o_job_data(job_data),
    .i_res_valid(res_valid),
    .i_res_hash(res_hash),
    .i_res_nonce(res_nonce),
    .o_ticket2moon(ticket2moon),
    .o_hash_cmplt(hash_cmplt),
    .o_win_valid(win_valid),
    .o_win_nonce(win_nonce),
    .i_win_rd(win_rd),
    .o_win_overflow(win_overflow),
    .o_busy(busy)
  );

  typedef struct {
    int          due;
    logic [31:0] n;
  } ret_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int cmplt_cnt = 0;
  int last_res_cyc = 0;
  int last_cmplt_cyc = 0;
  bit core_hold = 1'b0;
  bit prev_rv = 1'b0;
  logic [31:0] prev_rn = '0;

  ret_t        pipe[$];
  logic [31:0] held[$];
  logic [31:0] exp_job[$];
  logic [31:0] exp_tick[$];
  logic [31:0] wins[$];
  logic [607:0] exp_hdr = '0;
  logic [255:0] snap_tgt = '0;

  localparam logic [255:0] T = {1'b0, {239{1'b1}}, 16'h0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", nm, act);
  endtask

  // Winners return target or target-1; losers target+1 or an MSB-set hash
  function automatic logic [255:0] hash_of(input logic [31:0] n);
    for (int i = 0; i < wins.size(); i++)
      if (wins[i] == n)
        return n[0] ? snap_tgt : snap_tgt - 256'd1;
    return n[0] ? ({1'b1, 255'd0} | {224'd0, n}) : snap_tgt + 256'd1;
  endfunction

  // Behavioural hash core: answers each accepted job 3 cycles later
  initial begin
    res_valid = 1'b0;
    res_hash  = '0;
    res_nonce = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        res_valid = 1'b1;
        res_nonce = pipe[0].n;
        res_hash  = hash_of(pipe[0].n);
        void'(pipe.pop_front());
      end else begin
        res_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expected jobs and wins as the DUT presents them
  initial begin
    forever begin
      @(negedge clk);
      if (job_valid && job_ready) begin
        hs_cnt++;
        if (exp_job.size() == 0) begin
          fail_now("job_extra", {32'd0, job_data[639:608]});
        end else begin
          chk("job_nonce", {32'd0, job_data[639:608]},
              {32'd0, exp_job.pop_front()});
          chk("job_hdr", {63'd0, job_data[607:0] == exp_hdr}, 64'd1);
        end
        if (core_hold)
          held.push_back(job_data[639:608]);
        else
          pipe.push_back('{cyc + 4, job_data[639:608]});
      end
      if (res_valid)
        last_res_cyc = cyc;
      if (ticket2moon) begin
        if (exp_tick.size() == 0) begin
          fail_now("tick_extra", {32'd0, prev_rn});
        end else begin
          chk("tick_after_res", {63'd0, prev_rv}, 64'd1);
          chk("tick_nonce", {32'd0, prev_rn}, {32'd0, exp_tick.pop_front()});
        end
      end
      prev_rv = res_valid;
      prev_rn = res_nonce;
      if (hash_cmplt) begin
        cmplt_cnt++;
        last_cmplt_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [607:0] h, input logic [255:0] t,
                          input logic [31:0] s, input logic [31:0] e);
    header      = h;
    target      = t;
    nonce_start = s;
    nonce_end   = e;
    exp_hdr     = h;
    snap_tgt    = t;
    start       = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_jobs(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++)
      exp_job.push_back(s + 32'(i));
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, {63'd0, busy}, 64'd0);
  endtask

  task automatic end_test(input string nm);
    tick(2);
    chk({nm, "_jobs_left"}, 64'(exp_job.size()), 64'd0);
    chk({nm, "_ticks_left"}, 64'(exp_tick.size()), 64'd0);
    exp_job.delete();
    exp_tick.delete();
  endtask

  task automatic pop_win;
    win_rd = 1'b1;
    tick(1);
    win_rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  int c0;
  int h0;

  initial begin
    rst         = 1'b1;
    header      = '0;
    target      = '0;
    nonce_start = '0;
    nonce_end   = '0;
    start       = 1'b0;
    brk         = 1'b0;
    job_ready   = 1'b0;
    win_rd      = 1'b0;
    tick(3);
    chk("rst_job_valid", {63'd0, job_valid}, 64'd0);
    chk("rst_ticket", {63'd0, ticket2moon}, 64'd0);
    chk("rst_cmplt", {63'd0, hash_cmplt}, 64'd0);
    chk("rst_win_valid", {63'd0, win_valid}, 64'd0);
    chk("rst_win_nonce", {32'd0, win_nonce}, 64'd0);
    chk("rst_overflow", {63'd0, win_overflow}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    tick(1);

    // 1: four losing nonces; inputs changed after start must not leak in
    job_ready = 1'b1;
    push_jobs(32'd10, 4);
    c0 = cmplt_cnt;
    h0 = hs_cnt;
    do_start({19{32'hA5A5_0001}}, T, 32'd10, 32'd13);
    header = {19{32'h5A5A_FFFE}};
    target = {256{1'b1}};
    chk("t1_busy", {63'd0, busy}, 64'd1);
    wait_idle("t1_idle", 200);
    chk("t1_hs", 64'(hs_cnt - h0), 64'd4);
    chk("t1_cmplt", 64'(cmplt_cnt - c0), 64'd1);
    chk("t1_cmplt_after_res",
        {63'd0, last_cmplt_cyc > last_res_cyc}, 64'd1);
    chk("t1_win_valid", {63'd0, win_valid}, 64'd0);
    end_test("t1");

    // 2: nonce 5 hashes exactly to target
    wins = '{32'd5};
    exp_tick.push_back(32'd5);
    push_jobs(32'd0, 8);
    c0 = cmplt_cnt;
    do_start({19{32'h1234_5678}}, T, 32'd0, 32'd7);
    wait_idle("t2_idle", 200);
    chk("t2_cmplt", 64'(cmplt_cnt - c0), 64'd1);
    chk("t2_win_valid", {63'd0, win_valid}, 64'd1);
    chk("t2_win_nonce", {32'd0, win_nonce}, 64'd5);
    pop_win();
    chk("t2_win_empty", {63'd0, win_valid}, 64'd0);
    chk("t2_overflow", {63'd0, win_overflow}, 64'd0);
    end_test("t2");

    // 3: core holds results; in-flight limit of 4
    wins.delete();
    core_hold = 1'b1;
    push_jobs(32'd100, 10);
    c0 = cmplt_cnt;
    h0 = hs_cnt;
    do_start({19{32'h0BAD_F00D}}, T, 32'd100, 32'd109);
    tick(12);
    chk("t3_hs_limit", 64'(hs_cnt - h0), 64'd4);
    chk("t3_valid_low", {63'd0, job_valid}, 64'd0);
    pipe.push_back('{cyc, held.pop_front()});
    tick(10);
    chk("t3_hs_one_more", 64'(hs_cnt - h0), 64'd5);
    chk("t3_valid_low2", {63'd0, job_valid}, 64'd0);
    core_hold = 1'b0;
    while (held.size() > 0)
      pipe.push_back('{cyc, held.pop_front()});
    wait_idle("t3_idle", 400);
    chk("t3_cmplt", 64'(cmplt_cnt - c0), 64'd1);
    end_test("t3");

    // 4: break with 3 outstanding; returns still compared, no cmplt
    wins = '{32'd201};
    exp_tick.push_back(32'd201);
    push_jobs(32'd200, 3);
    core_hold = 1'b1;
    job_ready = 1'b0;
    c0 = cmplt_cnt;
    h0 = hs_cnt;
    do_start({19{32'hCAFE_BABE}}, T, 32'd200, 32'd299);
    job_ready = 1'b1;
    tick(3);
    job_ready = 1'b0;
    brk = 1'b1;
    tick(1);
    brk = 1'b0;
    job_ready = 1'b1;
    tick(8);
    chk("t4_hs", 64'(hs_cnt - h0), 64'd3);
    chk("t4_valid_low", {63'd0, job_valid}, 64'd0);
    chk("t4_busy_wait", {63'd0, busy}, 64'd1);
    core_hold = 1'b0;
    while (held.size() > 0)
      pipe.push_back('{cyc, held.pop_front()});
    wait_idle("t4_idle", 200);
    chk("t4_no_cmplt", 64'(cmplt_cnt - c0), 64'd0);
    chk("t4_win_nonce", {32'd0, win_nonce}, 64'd201);
    pop_win();
    end_test("t4");

    // 5: six winners into a 4-deep FIFO
    wins = '{32'd300, 32'd301, 32'd302, 32'd303, 32'd304, 32'd305};
    for (int i = 0; i < 6; i++)
      exp_tick.push_back(32'd300 + 32'(i));
    push_jobs(32'd300, 6);
    c0 = cmplt_cnt;
    do_start({19{32'h0D0C_0001}}, T, 32'd300, 32'd305);
    wait_idle("t5_idle", 200);
    chk("t5_cmplt", 64'(cmplt_cnt - c0), 64'd1);
    chk("t5_overflow", {63'd0, win_overflow}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_win_valid", {63'd0, win_valid}, 64'd1);
      chk("t5_win_nonce", {32'd0, win_nonce}, 64'd300 + 64'(i));
      pop_win();
    end
    chk("t5_win_empty", {63'd0, win_valid}, 64'd0);
    pop_win();
    chk("t5_pop_empty", {63'd0, win_valid}, 64'd0);
    chk("t5_overflow_sticky", {63'd0, win_overflow}, 64'd1);
    end_test("t5");

    // 6: top of nonce space, then an empty range
    wins.delete();
    exp_job.push_back(32'hFFFF_FFFE);
    exp_job.push_back(32'hFFFF_FFFF);
    c0 = cmplt_cnt;
    h0 = hs_cnt;
    do_start({19{32'h7777_0006}}, T, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    chk("t6_overflow_clr", {63'd0, win_overflow}, 64'd0);
    wait_idle("t6_idle", 200);
    chk("t6_hs", 64'(hs_cnt - h0), 64'd2);
    chk("t6_cmplt", 64'(cmplt_cnt - c0), 64'd1);
    end_test("t6");
    c0 = cmplt_cnt;
    h0 = hs_cnt;
    do_start({19{32'h7777_0007}}, T, 32'd5, 32'd4);
    chk("t6e_busy", {63'd0, busy}, 64'd1);
    wait_idle("t6e_idle", 50);
    chk("t6e_hs", 64'(hs_cnt - h0), 64'd0);
    chk("t6e_cmplt", 64'(cmplt_cnt - c0), 64'd1);
    end_test("t6e");

    // 7: reset mid-scan discards the scan with no cmplt
    push_jobs(32'd400, 11);
    c0 = cmplt_cnt;
    do_start({19{32'h4444_0008}}, T, 32'd400, 32'd410);
    tick(4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_job.delete();
    pipe.delete();
    held.delete();
    chk("t7_busy", {63'd0, busy}, 64'd0);
    chk("t7_valid", {63'd0, job_valid}, 64'd0);
    chk("t7_win_valid", {63'd0, win_valid}, 64'd0);
    tick(10);
    chk("t7_no_cmplt", 64'(cmplt_cnt - c0), 64'd0);
    chk("t7_busy_after", {63'd0, busy}, 64'd0);
    end_test("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
